// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for a multicycle RV32 subset (lw, sw, R, I, beq/bne, jal).
// Moore control decodes of State; PCWrite adds the branch condition.
module multicycle_ctrl_fsm (
    input  logic        CLK,
    input  logic        RST,
    input  logic [6:0]  Op,
    input  logic        Funct3_0,
    input  logic        Zero,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        Illegal,
    output logic [15:0] Retired,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_e      state_q, state_d;
    logic [15:0] retired_q, retired_d;
    logic        retire;

    logic       pc_update, branch, adr_src, mem_write_s, ir_write_s, reg_write_s, illegal_s;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BR) || (op == OP_JAL);
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:    state_d = S_FETCH;
        endcase
        retired_d = (retire && (retired_q != 16'hFFFF)) ? retired_q + 16'd1 : retired_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        pc_update   = 1'b0;
        branch      = 1'b0;
        adr_src     = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        illegal_s   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                illegal_s = !op_supported(Op);
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB:    reg_write_s = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are gated by RST so an asserted reset silences them before the state flops settle.
    assign PCWrite   = RST & (pc_update | (branch & (Zero ^ Funct3_0)));
    assign MemWrite  = RST & mem_write_s;
    assign IRWrite   = RST & ir_write_s;
    assign RegWrite  = RST & reg_write_s;
    assign AdrSrc    = adr_src;
    assign ResultSrc = result_src;
    assign ALUSrcA   = alu_src_a;
    assign ALUSrcB   = alu_src_b;
    assign ALUOp     = alu_op;
    assign Illegal   = illegal_s;
    assign Retired   = retired_q;
    assign State     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed and random instructions
// compared against an instruction-level model of the control sequence.
module tb_multicycle_ctrl_fsm;

    typedef int path_t[$];

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic        CLK, RST, Funct3_0, Zero;
    logic [6:0]  Op;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [15:0] Retired;
    logic [3:0]  State;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_retired = 16'd0;

    multicycle_ctrl_fsm dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Funct3_0(Funct3_0), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .Illegal(Illegal), .Retired(Retired), .State(State)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL};
    endfunction

    // Expected state walk of one instruction, starting at FETCH.
    function automatic path_t exp_path(input logic [6:0] op);
        path_t p;
        p = {0, 1};
        case (op)
            OP_LW:   begin p.push_back(2); p.push_back(3); p.push_back(4); end
            OP_SW:   begin p.push_back(2); p.push_back(5); end
            OP_R:    begin p.push_back(6); p.push_back(8); end
            OP_I:    begin p.push_back(7); p.push_back(8); end
            OP_BR:   p.push_back(9);
            OP_JAL:  begin p.push_back(10); p.push_back(8); end
            default: ;
        endcase
        return p;
    endfunction

    // Packed {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal, Retired}.
    function automatic logic [33:0] exp_ctrl(input int st, input bit unsup, input bit f3,
                                             input bit z, input logic [15:0] ret);
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, a, b, aop;
        pcw = (st == 0) || (st == 10) || ((st == 9) && (z ^ f3));
        adr = (st == 3) || (st == 5);
        mw  = (st == 5);
        irw = (st == 0);
        rw  = (st == 4) || (st == 8);
        ill = (st == 1) && unsup;
        rs = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
        case (st)
            0:  begin rs = 2'b10; b = 2'b10; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            4:  rs = 2'b01;
            6:  begin a = 2'b10; aop = 2'b10; end
            7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            9:  begin a = 2'b10; aop = 2'b01; end
            10: begin a = 2'b01; b = 2'b10; end
            default: ;
        endcase
        return {4'(st), pcw, adr, mw, irw, rw, rs, a, b, aop, ill, ret};
    endfunction

    function automatic logic [33:0] observed();
        return {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal, Retired};
    endfunction

    // Runs one instruction from FETCH; zero_sel 0/1 fixes Zero, 2 randomises it every cycle.
    task automatic run_instr(input logic [6:0] op, input logic f3, input int zero_sel, input string tag);
        path_t       p;
        logic [33:0] exp_v, act_v;
        bit          unsup;
        p     = exp_path(op);
        unsup = !is_legal(op);
        Op       = op;
        Funct3_0 = f3;
        for (int i = 0; i < p.size(); i++) begin
            Zero = (zero_sel == 2) ? 1'($urandom_range(0, 1)) : 1'(zero_sel);
            @(negedge CLK);
            exp_v = exp_ctrl(p[i], unsup, f3, Zero, exp_retired);
            act_v = observed();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s op=%b cycle %0d: got %h expected %h", tag, op, i, act_v, exp_v);
            end
            @(posedge CLK);
            #1;
        end
        if (!unsup && exp_retired != 16'hFFFF) exp_retired = exp_retired + 16'd1;
        checks++;
        if ({State, Retired} !== {4'd0, exp_retired}) begin
            errors++;
            $display("FAIL %s_end op=%b: got state %0d retired %h expected state 0 retired %h",
                     tag, op, State, Retired, exp_retired);
        end
    endtask

    task automatic test_reset();
        logic [33:0] exp_v;
        exp_v = {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 16'd0};
        Op = OP_BR; Funct3_0 = 1'b0; Zero = 1'b1;
        @(negedge CLK);
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL reset_hold_a: got %h expected %h", observed(), exp_v);
        end
        Op = 7'h7F; Funct3_0 = 1'b1; Zero = 1'b0;
        @(negedge CLK);
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL reset_hold_b: got %h expected %h", observed(), exp_v);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        exp_retired = 16'd0;
    endtask

    task automatic test_lw_sw();
        run_instr(OP_LW, 1'b0, 2, "lw");
        run_instr(OP_SW, 1'b1, 2, "sw");
    endtask

    task automatic test_branch();
        for (int f = 0; f < 2; f++)
            for (int z = 0; z < 2; z++)
                run_instr(OP_BR, 1'(f), z, "branch");
    endtask

    task automatic test_illegal();
        run_instr(7'b1111111, 1'b0, 2, "illegal_ff");
        run_instr(7'b0000000, 1'b1, 2, "illegal_00");
    endtask

    task automatic test_random();
        logic [6:0] legal_ops[6];
        logic [6:0] op;
        legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL};
        for (int n = 0; n < 200; n++) begin
            int r;
            r  = int'($urandom_range(0, 7));
            op = (r < 6) ? legal_ops[r] : 7'($urandom);
            run_instr(op, 1'($urandom_range(0, 1)), 2, "random");
        end
    endtask

    task automatic test_reset_abort();
        Op = OP_SW; Funct3_0 = 1'b0; Zero = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        checks++;
        if ({State, MemWrite, AdrSrc} !== {4'd5, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL abort_pre: got state %0d memwrite %b adrsrc %b expected 5 1 1",
                     State, MemWrite, AdrSrc);
        end
        #1 RST = 1'b0;
        #1;
        exp_retired = 16'd0;
        checks++;
        if ({State, MemWrite, IRWrite, PCWrite, RegWrite, Retired} !== {4'd0, 4'b0000, 16'd0}) begin
            errors++;
            $display("FAIL abort_async: got state %0d we %b%b%b%b retired %h expected 0 0000 0000",
                     State, MemWrite, IRWrite, PCWrite, RegWrite, Retired);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (State !== 4'd1) begin
            errors++;
            $display("FAIL abort_release: got state %0d expected 1", State);
        end
        Op = 7'h7F;
        @(posedge CLK);
        #1;
        checks++;
        if ({State, Retired} !== {4'd0, 16'd0}) begin
            errors++;
            $display("FAIL abort_return: got state %0d retired %h expected 0 0000", State, Retired);
        end
    endtask

    task automatic test_saturation();
        // Preload the counter just below the limit instead of retiring 65k instructions.
        force dut.retired_q = 16'hFFFC;
        #1;
        release dut.retired_q;
        exp_retired = 16'hFFFC;
        for (int n = 0; n < 6; n++) run_instr(OP_R, 1'b0, 2, "saturate");
        checks++;
        if (Retired !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate_hold: got %h expected ffff", Retired);
        end
    endtask

    initial begin
        RST = 1'b0; Op = 7'd0; Funct3_0 = 1'b0; Zero = 1'b0;
        test_reset();
        test_lw_sw();
        test_branch();
        test_illegal();
        run_instr(OP_R, 1'b0, 2, "rtype");
        run_instr(OP_I, 1'b1, 2, "itype");
        run_instr(OP_JAL, 1'b0, 2, "jal");
        test_random();
        test_reset_abort();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
